// File: rtl/debug_input.sv
`default_nettype none
// ============================================================================
// Module   : debug_input
// Purpose  : Synchronizes and debounces the board buttons and mode switches.
//            Produces clean levels, one-cycle press/release pulses and the
//            registered func select with a change pulse.
// Revision : 1.0 - initial release
// ============================================================================
module debug_input #(
    parameter int N_BTN         = 8,
    parameter int DEBOUNCE_BITS = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [1:0]       sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [1:0]       func,
    output logic             func_change
);

    // Buttons occupy the low channels, the two switch bits the top two.
    localparam int c_NCH = N_BTN + 2;
    localparam logic [DEBOUNCE_BITS-1:0] c_CNT_ONE = 1;
    localparam logic [DEBOUNCE_BITS-1:0] c_CNT_MAX = '1;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

    logic [c_NCH-1:0] r_sync1;
    logic [c_NCH-1:0] r_sync2;
    logic [c_NCH-1:0] r_level;
    logic [c_NCH-1:0] w_level_nxt;
    logic [N_BTN-1:0] r_btn_press;
    logic [N_BTN-1:0] r_btn_release;
    logic             r_func_change;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {sw_raw, btn_raw};
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < c_NCH; g++) begin : g_ch
        db_state_e                r_state;
        db_state_e                w_state_nxt;
        logic [DEBOUNCE_BITS-1:0] r_cnt;
        logic [DEBOUNCE_BITS-1:0] w_cnt_nxt;
        logic                     w_lvl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Any sample that agrees with the current level restarts the window.
        always_comb begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
            w_lvl       = r_level[g];
            if (r_sync2[g] != r_level[g]) begin
                if ((r_state == ST_PENDING) && (r_cnt == c_CNT_MAX)) begin
                    w_lvl = r_sync2[g];
                end else begin
                    w_state_nxt = ST_PENDING;
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
        end

        assign w_level_nxt[g] = w_lvl;
    end

    // Pulses are registered alongside the level so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level       <= '0;
            r_btn_press   <= '0;
            r_btn_release <= '0;
            r_func_change <= 1'b0;
        end else begin
            r_level       <= w_level_nxt;
            r_btn_press   <= w_level_nxt[N_BTN-1:0] & ~r_level[N_BTN-1:0];
            r_btn_release <= ~w_level_nxt[N_BTN-1:0] & r_level[N_BTN-1:0];
            r_func_change <= (w_level_nxt[c_NCH-1:N_BTN] != r_level[c_NCH-1:N_BTN]);
        end
    end

    assign btn_level   = r_level[N_BTN-1:0];
    assign func        = r_level[c_NCH-1:N_BTN];
    assign btn_press   = r_btn_press;
    assign btn_release = r_btn_release;
    assign func_change = r_func_change;

endmodule
`default_nettype wire

// File: tb/tb_debug_input.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_input
// Purpose  : Self-checking bench for debug_input with DEBOUNCE_BITS=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_input;

    localparam int N_BTN = 8;
    localparam int DB    = 4;
    localparam int WIN   = 1 << DB;
    localparam int NCH   = N_BTN + 2;
    localparam int LAT   = 18;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic [N_BTN-1:0] btn_raw = '0;
    logic [1:0]       sw_raw  = '0;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [1:0]       func;
    logic             func_change;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debug_input #(
        .N_BTN         (N_BTN),
        .DEBOUNCE_BITS (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .sw_raw      (sw_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .func        (func),
        .func_change (func_change)
    );

    // Reference: a level flips once WIN consecutive synchronized samples disagree with it.
    logic [NCH-1:0] m_s1   = '0;
    logic [NCH-1:0] m_s2   = '0;
    logic [NCH-1:0] m_lvl  = '0;
    logic [NCH-1:0] m_prev = '0;
    int             m_streak [NCH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1   = '0;
            m_s2   = '0;
            m_lvl  = '0;
            m_prev = '0;
            for (int i = 0; i < NCH; i++) m_streak[i] = 0;
        end else begin
            m_prev = m_lvl;
            for (int i = 0; i < NCH; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_streak[i] = m_streak[i] + 1;
                    if (m_streak[i] == WIN) begin
                        m_lvl[i]    = m_s2[i];
                        m_streak[i] = 0;
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {sw_raw, btn_raw};
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst_n   = 1'b0;
        btn_raw = '0;
        sw_raw  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({btn_level, btn_press, btn_release} !== 24'h0)
            $display("FAIL reset_btn: got %h required 000000", {btn_level, btn_press, btn_release});
        checks++;
        if ({func, func_change} !== 3'b000)
            $display("FAIL reset_func: got %b required 000", {func, func_change});
        btn_raw = 8'hFF;
        sw_raw  = 2'b11;
        repeat (20) @(negedge clk);
        checks++;
        if ({btn_level, btn_press, func, func_change} !== 19'h0)
            $display("FAIL reset_hold: got %h required 0", {btn_level, btn_press, func, func_change});
        if (|{btn_level, btn_press, func, func_change}) errors++;
        if ({btn_level, btn_press, btn_release} !== 24'h0 && {btn_level, btn_press, func, func_change} === 19'h0) errors++;
        if ({func, func_change} !== 3'b000) errors++;
        do_reset;
    endtask

    task automatic test_single_press;
        logic [7:0] exp_lvl, exp_prs;
        do_reset;
        btn_raw = 8'h01;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_lvl = (k >= LAT) ? 8'h01 : 8'h00;
            exp_prs = (k == LAT) ? 8'h01 : 8'h00;
            checks++;
            if (btn_level !== exp_lvl) begin
                errors++;
                $display("FAIL single_level edge=%0d: got %h required %h", k, btn_level, exp_lvl);
            end
            checks++;
            if (btn_press !== exp_prs) begin
                errors++;
                $display("FAIL single_press edge=%0d: got %h required %h", k, btn_press, exp_prs);
            end
            checks++;
            if (btn_release !== 8'h00) begin
                errors++;
                $display("FAIL single_release edge=%0d: got %h required 00", k, btn_release);
            end
        end
    endtask

    task automatic test_glitch;
        do_reset;
        btn_raw = 8'h08;
        for (int k = 1; k <= 40; k++) begin
            if (k == 11) btn_raw = 8'h00;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({btn_level, btn_press, btn_release} !== 24'h0) begin
                errors++;
                $display("FAIL glitch edge=%0d: got %h required 000000", k, {btn_level, btn_press, btn_release});
            end
        end
    endtask

    task automatic test_bounce;
        int         n_press;
        logic [7:0] exp_prs;
        do_reset;
        n_press = 0;
        for (int p = 0; p < 4; p++) begin
            btn_raw = (p % 2 == 0) ? 8'h20 : 8'h00;
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
                if (btn_press[5]) n_press++;
            end
        end
        btn_raw = 8'h20;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (btn_press[5]) n_press++;
            exp_prs = (k == LAT) ? 8'h20 : 8'h00;
            checks++;
            if (btn_press !== exp_prs) begin
                errors++;
                $display("FAIL bounce_press edge=%0d: got %h required %h", k, btn_press, exp_prs);
            end
        end
        checks++;
        if (n_press != 1) begin
            errors++;
            $display("FAIL bounce_count: got %0d pulses required 1", n_press);
        end
    endtask

    task automatic test_all_channels;
        logic [7:0] exp_p;
        do_reset;
        btn_raw = 8'hFF;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_p = (k == LAT) ? 8'hFF : 8'h00;
            checks++;
            if ({btn_press, btn_release} !== {exp_p, 8'h00}) begin
                errors++;
                $display("FAIL all_press edge=%0d: got %h/%h required %h/00", k, btn_press, btn_release, exp_p);
            end
        end
        btn_raw = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_p = (k == LAT) ? 8'hFF : 8'h00;
            checks++;
            if ({btn_press, btn_release} !== {8'h00, exp_p}) begin
                errors++;
                $display("FAIL all_release edge=%0d: got %h/%h required 00/%h", k, btn_press, btn_release, exp_p);
            end
            checks++;
            if (btn_level !== ((k >= LAT) ? 8'h00 : 8'hFF)) begin
                errors++;
                $display("FAIL all_level edge=%0d: got %h", k, btn_level);
            end
        end
    endtask

    task automatic test_func;
        logic [1:0] exp_f;
        logic       exp_c;
        do_reset;
        sw_raw = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_f = (k >= LAT) ? 2'b10 : 2'b00;
            exp_c = (k == LAT);
            checks++;
            if ({func, func_change} !== {exp_f, exp_c}) begin
                errors++;
                $display("FAIL func_a edge=%0d: got %b/%b required %b/%b", k, func, func_change, exp_f, exp_c);
            end
        end
        sw_raw = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_f = (k >= LAT) ? 2'b01 : 2'b10;
            exp_c = (k == LAT);
            checks++;
            if ({func, func_change} !== {exp_f, exp_c}) begin
                errors++;
                $display("FAIL func_b edge=%0d: got %b/%b required %b/%b", k, func, func_change, exp_f, exp_c);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp_prs;
        do_reset;
        btn_raw = 8'h01;
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({btn_level, btn_press, btn_release} !== 24'h0) begin
                errors++;
                $display("FAIL midreset_hold k=%0d: got %h required 000000", k, {btn_level, btn_press, btn_release});
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_prs = (k == LAT) ? 8'h01 : 8'h00;
            checks++;
            if (btn_press !== exp_prs) begin
                errors++;
                $display("FAIL midreset_press edge=%0d: got %h required %h", k, btn_press, exp_prs);
            end
        end
    endtask

    task automatic test_random;
        int hold;
        do_reset;
        for (int s = 0; s < 60; s++) begin
            btn_raw = 8'($urandom);
            sw_raw  = 2'($urandom);
            hold    = int'($urandom_range(1, 24));
            for (int c = 0; c < hold; c++) begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if ({func, btn_level} !== m_lvl) begin
                    errors++;
                    $display("FAIL rand_level seg=%0d: got %h required %h", s, {func, btn_level}, m_lvl);
                end
                checks++;
                if (btn_press !== (m_lvl[7:0] & ~m_prev[7:0])) begin
                    errors++;
                    $display("FAIL rand_press seg=%0d: got %h required %h", s, btn_press, m_lvl[7:0] & ~m_prev[7:0]);
                end
                checks++;
                if (btn_release !== (~m_lvl[7:0] & m_prev[7:0])) begin
                    errors++;
                    $display("FAIL rand_release seg=%0d: got %h required %h", s, btn_release, ~m_lvl[7:0] & m_prev[7:0]);
                end
                checks++;
                if (func_change !== (m_lvl[9:8] != m_prev[9:8])) begin
                    errors++;
                    $display("FAIL rand_func_change seg=%0d: got %b required %b", s, func_change, m_lvl[9:8] != m_prev[9:8]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_glitch;
        test_bounce;
        test_all_channels;
        test_func;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
